// File: rtl/data_pack_pkg.sv
// Shared constants and helpers for the narrow/wide packing datapath.
// Used by data_packing and its companion data_unpacking so both sides
// agree on default widths and on the lane-count arithmetic.
package data_pack_pkg;

  localparam int DEFAULT_IN_WIDTH  = 16;
  localparam int DEFAULT_OUT_WIDTH = 32;

  // Ceiling log2; clog2(1) = 0, clog2(2) = 1, clog2(3) = 2.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      result++;
    end
    return result;
  endfunction

endpackage

// File: rtl/data_packing.sv
// data_packing: gathers RATIO = OUT_DATA_WIDTH/IN_DATA_WIDTH narrow words,
// LSB lane first, into one wide word and emits it with a one-cycle pulse.
// A flush emits a partially filled word (unfilled lanes zero).
//
// Ports
//   clk          rising-edge clock
//   rst          synchronous active-high reset; discards any partial group
//   pack_enable  in_data is presented this cycle
//   window_en    stall gate; low freezes counter, accumulator and busy
//   flush        emit the pending partial word
//   in_data      narrow input word
//   out_data     packed word, held between pulses
//   out_valid    one-cycle pulse qualifying out_data
//   out_lanes    number of valid lanes in out_data
//   busy         at least one lane is held and not yet emitted
//
// RATIO must be an integer >= 2.
module data_packing
  import data_pack_pkg::*;
#(
  parameter int  IN_DATA_WIDTH  = DEFAULT_IN_WIDTH,
  parameter int  OUT_DATA_WIDTH = DEFAULT_OUT_WIDTH,
  localparam int RATIO          = OUT_DATA_WIDTH / IN_DATA_WIDTH,
  localparam int CW             = clog2(RATIO),
  localparam int LW             = CW + 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      pack_enable,
  input  logic                      window_en,
  input  logic                      flush,
  input  logic [IN_DATA_WIDTH-1:0]  in_data,
  output logic [OUT_DATA_WIDTH-1:0] out_data,
  output logic                      out_valid,
  output logic [LW-1:0]             out_lanes,
  output logic                      busy
);

  logic [CW-1:0]             cnt_q, cnt_d;
  logic [OUT_DATA_WIDTH-1:0] acc_q, acc_d;
  logic [OUT_DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic                      out_valid_q, out_valid_d;
  logic [LW-1:0]             out_lanes_q, out_lanes_d;

  logic                      accept;
  logic [OUT_DATA_WIDTH-1:0] acc_next;
  logic [LW-1:0]             lanes_next;
  logic                      emit;

  assign accept = pack_enable & window_en;

  always_comb begin
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    out_data_d  = out_data_q;
    out_lanes_d = out_lanes_q;
    out_valid_d = 1'b0;

    // Merge this cycle's word first so a coincident flush includes it.
    acc_next   = acc_q;
    lanes_next = {1'b0, cnt_q};
    for (int i = 0; i < RATIO; i++) begin
      if (accept && cnt_q == CW'(i)) begin
        acc_next[i*IN_DATA_WIDTH +: IN_DATA_WIDTH] = in_data;
      end
    end
    if (accept) begin
      lanes_next = lanes_next + LW'(1);
    end

    emit = (lanes_next == LW'(RATIO)) || (flush && lanes_next != '0);

    if (window_en) begin
      if (emit) begin
        out_data_d  = acc_next;
        out_lanes_d = lanes_next;
        out_valid_d = 1'b1;
        cnt_d       = '0;
        // Cleared so the next partial flush shows zeros in unfilled lanes.
        acc_d       = '0;
      end else begin
        cnt_d = lanes_next[CW-1:0];
        acc_d = acc_next;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q       <= '0;
      acc_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_lanes_q <= '0;
    end else begin
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_lanes_q <= out_lanes_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_lanes = out_lanes_q;
  assign busy      = (cnt_q != '0);

endmodule

// File: tb/tb_data_packing.sv
// Self-checking bench for data_packing (default 16 -> 32 packing).
module tb_data_packing;

  localparam int IW    = 16;
  localparam int OW    = 32;
  localparam int RATIO = OW / IW;

  logic          clk;
  logic          rst;
  logic          pack_enable;
  logic          window_en;
  logic          flush;
  logic [IW-1:0] in_data;
  logic [OW-1:0] out_data;
  logic          out_valid;
  logic [1:0]    out_lanes;
  logic          busy;

  int n_checks = 0;
  int n_fail   = 0;

  data_packing #(.IN_DATA_WIDTH(IW), .OUT_DATA_WIDTH(OW)) dut (
    .clk        (clk),
    .rst        (rst),
    .pack_enable(pack_enable),
    .window_en  (window_en),
    .flush      (flush),
    .in_data    (in_data),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_lanes  (out_lanes),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of inputs, then land 1 time unit after the edge that samples them.
  task automatic cycle(input logic r, input logic pe, input logic we, input logic fl,
                       input logic [IW-1:0] d);
    rst = r; pack_enable = pe; window_en = we; flush = fl; in_data = d;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    cycle(1, 0, 1, 0, '0);
    cycle(1, 1, 1, 1, 16'hFFFF);
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
    n_checks++; if (out_data !== 32'h0) begin n_fail++; $display("FAIL reset_data got=%h exp=0", out_data); end
    n_checks++; if (out_lanes !== 2'd0) begin n_fail++; $display("FAIL reset_lanes got=%0d exp=0", out_lanes); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
  endtask

  task automatic test_full_word;
    cycle(0, 1, 1, 0, 16'h1111);
    n_checks++; if (out_valid !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL full_first valid=%b busy=%b exp valid=0 busy=1", out_valid, busy); end
    cycle(0, 1, 1, 0, 16'h2222);
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL full_valid got=%b exp=1", out_valid); end
    n_checks++; if (out_data !== 32'h22221111) begin n_fail++; $display("FAIL full_data got=%h exp=22221111", out_data); end
    n_checks++; if (out_lanes !== 2'd2) begin n_fail++; $display("FAIL full_lanes got=%0d exp=2", out_lanes); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL full_busy got=%b exp=0", busy); end
    cycle(0, 0, 1, 0, '0);
    n_checks++; if (out_valid !== 1'b0 || out_data !== 32'h22221111) begin n_fail++; $display("FAIL full_hold valid=%b data=%h exp valid=0 data=22221111", out_valid, out_data); end
  endtask

  task automatic test_flush;
    cycle(0, 1, 1, 0, 16'hAAAA);
    cycle(0, 0, 1, 1, '0);
    n_checks++; if (out_valid !== 1'b1 || out_data !== 32'h0000AAAA || out_lanes !== 2'd1) begin
      n_fail++; $display("FAIL flush_partial valid=%b data=%h lanes=%0d exp 1/0000aaaa/1", out_valid, out_data, out_lanes); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL flush_busy got=%b exp=0", busy); end
    cycle(0, 0, 1, 1, '0);
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_idle got=%b exp=0", out_valid); end
    // Flush coincident with an accept: the accepted word is included.
    cycle(0, 1, 1, 1, 16'h5A5A);
    n_checks++; if (out_valid !== 1'b1 || out_data !== 32'h00005A5A || out_lanes !== 2'd1) begin
      n_fail++; $display("FAIL flush_accept_one valid=%b data=%h lanes=%0d exp 1/00005a5a/1", out_valid, out_data, out_lanes); end
    cycle(0, 1, 1, 0, 16'h0C0C);
    cycle(0, 1, 1, 1, 16'hD0D0);
    n_checks++; if (out_valid !== 1'b1 || out_data !== 32'hD0D00C0C || out_lanes !== 2'd2) begin
      n_fail++; $display("FAIL flush_accept_full valid=%b data=%h lanes=%0d exp 1/d0d00c0c/2", out_valid, out_data, out_lanes); end
    cycle(0, 0, 1, 0, '0);
    n_checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL flush_after valid=%b busy=%b exp 0/0", out_valid, busy); end
  endtask

  task automatic test_window_stall;
    cycle(0, 1, 1, 0, 16'hAAAA);
    for (int i = 0; i < 3; i++) begin
      cycle(0, 1, 0, (i == 1), 16'hDEAD);
      n_checks++; if (out_valid !== 1'b0 || busy !== 1'b1) begin
        n_fail++; $display("FAIL stall_%0d valid=%b busy=%b exp 0/1", i, out_valid, busy); end
    end
    cycle(0, 1, 1, 0, 16'hBBBB);
    n_checks++; if (out_valid !== 1'b1 || out_data !== 32'hBBBBAAAA || out_lanes !== 2'd2) begin
      n_fail++; $display("FAIL stall_resume valid=%b data=%h lanes=%0d exp 1/bbbbaaaa/2", out_valid, out_data, out_lanes); end
    cycle(0, 1, 0, 0, 16'h1234);
    n_checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL stall_pulse_drop valid=%b busy=%b exp 0/0", out_valid, busy); end
  endtask

  task automatic test_reset_discard;
    cycle(0, 1, 1, 0, 16'h1234);
    cycle(1, 0, 1, 0, '0);
    n_checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL rst_discard valid=%b busy=%b exp 0/0", out_valid, busy); end
    cycle(0, 1, 1, 0, 16'h5678);
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_no_pulse got=%b exp=0", out_valid); end
    cycle(0, 1, 1, 0, 16'h9ABC);
    n_checks++; if (out_valid !== 1'b1 || out_data !== 32'h9ABC5678 || out_lanes !== 2'd2) begin
      n_fail++; $display("FAIL rst_next valid=%b data=%h lanes=%0d exp 1/9abc5678/2", out_valid, out_data, out_lanes); end
  endtask

  task automatic test_back_to_back;
    logic [OW-1:0] exp;
    int pulses;
    pulses = 0;
    for (int i = 1; i <= 8; i++) begin
      cycle(0, 1, 1, 0, IW'(i));
      if (i % 2 == 0) begin
        exp = {IW'(i), IW'(i - 1)};
        pulses++;
        n_checks++; if (out_valid !== 1'b1 || out_data !== exp) begin
          n_fail++; $display("FAIL stream_%0d valid=%b data=%h exp 1/%h", i, out_valid, out_data, exp); end
      end else begin
        n_checks++; if (out_valid !== 1'b0) begin
          n_fail++; $display("FAIL stream_gap_%0d valid=%b exp 0", i, out_valid); end
      end
    end
    n_checks++; if (pulses != 4) begin n_fail++; $display("FAIL stream_count got=%0d exp=4", pulses); end
    cycle(0, 0, 1, 0, '0);
  endtask

  // Random stimulus against a queue model; lanes from each pulse are unpacked
  // LSB first and the recovered stream must equal the accepted stream.
  task automatic test_random_loopback;
    logic [IW-1:0] pend[$];
    logic [IW-1:0] sent[$];
    logic [IW-1:0] got[$];
    logic [OW-1:0] exp_data;
    logic [1:0]    exp_lanes;
    logic          exp_valid;
    logic          pe, we, fl;
    logic [IW-1:0] d;
    int            guard;
    int            bad;
    cycle(1, 0, 1, 0, '0);
    exp_data = '0; exp_lanes = '0;
    guard = 0;
    while (!(sent.size() >= 100 && pend.size() == 0) && guard < 3000) begin
      guard++;
      if (sent.size() >= 100) begin
        pe = 0; we = 1; fl = 1;
      end else begin
        we = ($urandom_range(0, 7) != 0);
        pe = ($urandom_range(0, 3) != 0);
        fl = ($urandom_range(0, 9) == 0);
      end
      d = IW'($urandom);
      exp_valid = 0;
      if (we) begin
        if (pe) begin pend.push_back(d); sent.push_back(d); end
        if (pend.size() == RATIO || (fl && pend.size() > 0)) begin
          exp_valid = 1;
          exp_lanes = 2'(pend.size());
          exp_data  = '0;
          foreach (pend[i]) exp_data[i*IW +: IW] = pend[i];
          pend.delete();
        end
      end
      cycle(0, pe, we, fl, d);
      n_checks++;
      if (out_valid !== exp_valid || busy !== (pend.size() != 0) ||
          (exp_valid && (out_data !== exp_data || out_lanes !== exp_lanes))) begin
        n_fail++;
        $display("FAIL rand_cycle_%0d valid=%b busy=%b data=%h lanes=%0d exp %b/%b/%h/%0d",
                 guard, out_valid, busy, out_data, out_lanes, exp_valid, (pend.size() != 0), exp_data, exp_lanes);
      end
      if (out_valid === 1'b1) begin
        for (int i = 0; i < RATIO; i++)
          if (i < int'(out_lanes)) got.push_back(out_data[i*IW +: IW]);
      end
    end
    n_checks++;
    if (guard >= 3000) begin n_fail++; $display("FAIL rand_timeout sent=%0d exp 100", sent.size()); end
    bad = 0;
    if (got.size() != sent.size()) bad = 1;
    else foreach (sent[i]) if (got[i] !== sent[i]) bad++;
    n_checks++;
    if (bad != 0) begin
      n_fail++; $display("FAIL loopback got_words=%0d exp_words=%0d bad=%0d", got.size(), sent.size(), bad);
    end
  endtask

  initial begin
    rst = 1; pack_enable = 0; window_en = 0; flush = 0; in_data = '0;
    test_reset();
    test_full_word();
    test_flush();
    test_window_stall();
    test_reset_discard();
    test_back_to_back();
    test_random_loopback();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
